// File: rtl/halt_bus_master.sv
// halt_bus_master
// Secondary bus initiator: halts the CPU through the halt_n / cpu_released
// handshake, runs byte-wide read or write bursts on the shared system bus
// (one access per CPU cycle, address phase on pclk1, completion on pclk0),
// steps aside for MARIA DMA, and returns the bus to the CPU after at most
// MAX_BURST accesses or at the end of the transfer.
module halt_bus_master #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pclk0,
  input  logic        pclk1,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [8:0]  req_len,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        halt_n,
  input  logic        cpu_released,
  input  logic        maria_drive_AB,
  output logic        bus_drive,
  output logic [15:0] AB_out,
  output logic        RW_out,
  output logic [7:0]  DB_out,
  input  logic [7:0]  DB_in
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ACCESS,
    PAUSE,
    RELEASE
  } state_t;

  state_t state, state_d;

  // Transfer context
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [8:0]    len_q, len_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [BW-1:0] burst_inc;

  // Next values of the registered outputs
  logic        halt_n_d;
  logic        bus_drive_d;
  logic [15:0] ab_d;
  logic        rw_d;
  logic [7:0]  db_d;
  logic        busy_d;
  logic        done_d;
  logic        wr_ack_d;
  logic        rd_valid_d;
  logic [7:0]  rd_data_d;

  // Register the FSM state, the transfer context and every output
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 16'h0000;
      len_q     <= 9'd0;
      burst_q   <= '0;
      halt_n    <= 1'b1;
      bus_drive <= 1'b0;
      AB_out    <= 16'h0000;
      RW_out    <= 1'b1;
      DB_out    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state     <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      halt_n    <= halt_n_d;
      bus_drive <= bus_drive_d;
      AB_out    <= ab_d;
      RW_out    <= rw_d;
      DB_out    <= db_d;
      busy      <= busy_d;
      done      <= done_d;
      wr_ack    <= wr_ack_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
    end
  end

  // Next-state logic: hold everything by default, pulses default low,
  // and whenever the bus is given up RW_out returns to read
  always_comb begin
    state_d     = state;
    we_d        = we_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    burst_inc   = burst_q + 1'b1;
    halt_n_d    = halt_n;
    bus_drive_d = bus_drive;
    ab_d        = AB_out;
    rw_d        = RW_out;
    db_d        = DB_out;
    busy_d      = busy;
    done_d      = 1'b0;
    wr_ack_d    = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data;

    case (state)
      IDLE: begin
        if (req) begin
          we_d     = req_we;
          addr_d   = req_addr;
          len_d    = (req_len == 9'd0) ? 9'd1 : req_len;
          burst_d  = '0;
          busy_d   = 1'b1;
          halt_n_d = 1'b0;
          state_d  = HALT;
        end
      end

      HALT: begin
        halt_n_d = 1'b0;
        if (pclk1 && cpu_released && !maria_drive_AB) begin
          bus_drive_d = 1'b1;
          ab_d        = addr_q;
          rw_d        = ~we_q;
          if (we_q) begin
            db_d = wr_data;
          end
          state_d = ACCESS;
        end else if (maria_drive_AB) begin
          bus_drive_d = 1'b0;
          rw_d        = 1'b1;
        end
      end

      ACCESS: begin
        if (pclk0) begin
          if (we_q) begin
            wr_ack_d = 1'b1;
          end else begin
            rd_data_d  = DB_in;
            rd_valid_d = 1'b1;
          end
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 9'd1;
          burst_d = burst_inc;
          if (len_q == 9'd1) begin
            bus_drive_d = 1'b0;
            rw_d        = 1'b1;
            halt_n_d    = 1'b1;
            state_d     = RELEASE;
          end else if (burst_inc == BW'(MAX_BURST)) begin
            bus_drive_d = 1'b0;
            rw_d        = 1'b1;
            halt_n_d    = 1'b1;
            state_d     = PAUSE;
          end else begin
            state_d = HALT;
          end
        end
      end

      PAUSE: begin
        bus_drive_d = 1'b0;
        rw_d        = 1'b1;
        halt_n_d    = 1'b1;
        if (pclk1 && !cpu_released) begin
          burst_d  = '0;
          halt_n_d = 1'b0;
          state_d  = HALT;
        end
      end

      RELEASE: begin
        bus_drive_d = 1'b0;
        rw_d        = 1'b1;
        halt_n_d    = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_halt_bus_master.sv
// tb_halt_bus_master
// Drives halt_bus_master against a 64 KiB RAM model, a CPU wrapper model
// that answers halt_n, and a four-phase pclk1/pclk0 generator. Expected
// accesses are queued when a request is issued and compared as the DUT
// reports each completed access.
module tb_halt_bus_master;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        pclk0 = 1'b0;
  logic        pclk1 = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [8:0]  req_len = 9'd0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ack;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        halt_n;
  logic        cpu_released = 1'b0;
  logic        maria_drive_AB = 1'b0;
  logic        bus_drive;
  logic [15:0] AB_out;
  logic        RW_out;
  logic [7:0]  DB_out;
  logic [7:0]  DB_in;

  logic [7:0]  mem [0:65535];
  logic [1:0]  phase = 2'd0;

  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [7:0]  wq[$];
  logic [7:0]  wr_src[$];
  int          burst_hist[$];

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  int done_count = 0;
  int window = 0;
  logic halt_prev = 1'b1;

  halt_bus_master #(.MAX_BURST(16)) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .pclk0          (pclk0),
    .pclk1          (pclk1),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .busy           (busy),
    .done           (done),
    .halt_n         (halt_n),
    .cpu_released   (cpu_released),
    .maria_drive_AB (maria_drive_AB),
    .bus_drive      (bus_drive),
    .AB_out         (AB_out),
    .RW_out         (RW_out),
    .DB_out         (DB_out),
    .DB_in          (DB_in)
  );

  always #5 clk_sys = ~clk_sys;

  assign DB_in = mem[AB_out];

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  // Queue the expected accesses, then pulse req for one clock
  task automatic apply_stimulus(input logic we, input logic [15:0] addr, input logic [8:0] len);
    int n;
    logic [15:0] a;
    logic [7:0] d;
    n = (len == 9'd0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = addr + 16'(i);
      exp_addr.push_back(a);
      if (we) begin
        d = wr_src.pop_front();
        wq.push_back(d);
        exp_data.push_back(d);
      end else begin
        exp_data.push_back(mem[a]);
      end
    end
    req_we   = we;
    req_addr = addr;
    req_len  = len;
    req      = 1'b1;
    tick();
    req      = 1'b0;
    check_output("req_halt_n", {31'b0, halt_n}, 32'd0);
    check_output("req_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int start;
    int t;
    start = done_count;
    t = 0;
    while (done_count == start && t < limit) begin
      tick();
      t++;
    end
    check_output("done_seen", 32'(done_count - start), 32'd1);
    check_output("end_halt_n", {31'b0, halt_n}, 32'd1);
    check_output("end_busy", {31'b0, busy}, 32'd0);
    check_output("sb_left", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic wait_acc(input int target, input int limit);
    int t;
    t = 0;
    while (acc_count < target && t < limit) begin
      tick();
      t++;
    end
    check_output("acc_reached", 32'(acc_count >= target), 32'd1);
  endtask

  // pclk phase generator, CPU wrapper model and RAM write port
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    forever begin
      @(negedge clk_sys);
      phase = phase + 2'd1;
      pclk1 = (phase == 2'd0);
      pclk0 = (phase == 2'd2);
      if (phase == 2'd1) begin
        cpu_released = ~halt_n;
      end
      if (pclk0 && bus_drive && !RW_out) begin
        mem[AB_out] = DB_out;
      end
    end
  end

  // Scoreboard and protocol monitor
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!rst) begin
        if (rd_valid || wr_ack) begin
          acc_count++;
          window++;
          if (exp_addr.size() == 0) begin
            check_output("acc_extra", {31'b0, rd_valid | wr_ack}, 32'd0);
          end else if (rd_valid) begin
            check_output("rd_addr", {16'b0, AB_out}, {16'b0, exp_addr.pop_front()});
            check_output("rd_data", {24'b0, rd_data}, {24'b0, exp_data.pop_front()});
          end else begin
            check_output("wr_addr", {16'b0, AB_out}, {16'b0, exp_addr.pop_front()});
            check_output("wr_data", {24'b0, DB_out}, {24'b0, exp_data.pop_front()});
            if (wq.size() > 0) begin
              void'(wq.pop_front());
            end
          end
        end
        if (!bus_drive) begin
          check_output("rw_idle", {31'b0, RW_out}, 32'd1);
        end
        if (done) begin
          done_count++;
          check_output("done_busy", {31'b0, busy}, 32'd0);
        end
        if (halt_n && !halt_prev) begin
          burst_hist.push_back(window);
          window = 0;
        end
      end else begin
        window = 0;
      end
      halt_prev = halt_n;
      wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  // Main test sequence
  initial begin
    int acc0;
    int done0;

    repeat (4) tick();
    check_output("rst_halt_n", {31'b0, halt_n}, 32'd1);
    check_output("rst_bus_drive", {31'b0, bus_drive}, 32'd0);
    check_output("rst_AB_out", {16'b0, AB_out}, 32'd0);
    check_output("rst_RW_out", {31'b0, RW_out}, 32'd1);
    check_output("rst_DB_out", {24'b0, DB_out}, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_done", {31'b0, done}, 32'd0);
    check_output("rst_rd_data", {24'b0, rd_data}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Load 11,22,33,44 at 0x2000, then read it back
    wr_src.push_back(8'h11); wr_src.push_back(8'h22);
    wr_src.push_back(8'h33); wr_src.push_back(8'h44);
    apply_stimulus(1'b1, 16'h2000, 9'd4);
    wait_done(2000);
    check_output("ram_2003", {24'b0, mem[16'h2003]}, 32'h44);
    acc0 = acc_count;
    apply_stimulus(1'b0, 16'h2000, 9'd4);
    wait_done(2000);
    check_output("rd4_count", 32'(acc_count - acc0), 32'd4);

    // Write AA,BB,CC at 0x1800 with a stray req while busy, then read back
    wr_src.push_back(8'hAA); wr_src.push_back(8'hBB); wr_src.push_back(8'hCC);
    acc0 = acc_count;
    apply_stimulus(1'b1, 16'h1800, 9'd3);
    repeat (3) tick();
    req_we = 1'b0; req_addr = 16'h0040; req_len = 9'd5; req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(2000);
    check_output("wr3_count", 32'(acc_count - acc0), 32'd3);
    check_output("ram_1801", {24'b0, mem[16'h1801]}, 32'hBB);
    apply_stimulus(1'b0, 16'h1800, 9'd3);
    wait_done(2000);

    // Burst split: 40 reads with MAX_BURST=16
    burst_hist.delete();
    acc0 = acc_count;
    apply_stimulus(1'b0, 16'h3000, 9'd40);
    wait_done(4000);
    check_output("split_count", 32'(acc_count - acc0), 32'd40);
    check_output("split_windows", 32'(burst_hist.size()), 32'd3);
    if (burst_hist.size() == 3) begin
      check_output("split_b0", 32'(burst_hist[0]), 32'd16);
      check_output("split_b1", 32'(burst_hist[1]), 32'd16);
      check_output("split_b2", 32'(burst_hist[2]), 32'd8);
    end

    // len 0 behaves as one access
    acc0 = acc_count;
    apply_stimulus(1'b0, 16'h0100, 9'd0);
    wait_done(2000);
    check_output("len0_count", 32'(acc_count - acc0), 32'd1);

    // MARIA takes the bus for 10 clocks mid-burst
    acc0 = acc_count;
    apply_stimulus(1'b0, 16'h4000, 9'd8);
    wait_acc(acc0 + 3, 2000);
    maria_drive_AB = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("maria_bus_drive", {31'b0, bus_drive}, 32'd0);
    end
    maria_drive_AB = 1'b0;
    wait_done(2000);
    check_output("maria_count", 32'(acc_count - acc0), 32'd8);

    // Reset after 2 of 8 accesses
    acc0 = acc_count;
    apply_stimulus(1'b0, 16'h5000, 9'd8);
    wait_acc(acc0 + 2, 2000);
    done0 = done_count;
    rst = 1'b1;
    tick();
    check_output("mid_rst_halt_n", {31'b0, halt_n}, 32'd1);
    check_output("mid_rst_bus_drive", {31'b0, bus_drive}, 32'd0);
    check_output("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_output("mid_rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    repeat (20) tick();
    check_output("mid_rst_no_done", 32'(done_count - done0), 32'd0);

    // Address wrap after reset: FFFE, FFFF, 0000
    acc0 = acc_count;
    apply_stimulus(1'b0, 16'hFFFE, 9'd3);
    wait_done(2000);
    check_output("wrap_count", 32'(acc_count - acc0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
